// File: rtl/updi_response_queue_handler_pkg.sv
// Shared UPDI definitions: FSM state and phase encodings plus protocol byte values,
// common to the TX-side and RX-side queue handlers.
package updi_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } updi_response_queue_handler_state;

  typedef enum logic {
    ECHO = 1'b0,
    RESP = 1'b1
  } updi_response_phase;

  localparam logic [7:0] UPDI_SYNCH = 8'h55;
  localparam logic [7:0] UPDI_ACK   = 8'h40;

endpackage

// File: rtl/updi_response_queue_handler_if.sv
// Control, status and RX FIFO signals of the UPDI response queue handler.
// The master side is the instruction sequencer together with the RX FIFO.
interface updi_response_queue_handler_if #(
  parameter int MAX_DATA_SIZE  = 16,
  parameter int DATA_ADDR_BITS = $clog2(MAX_DATA_SIZE)
);
  logic                          start;
  logic                          ready;
  logic                          done;
  logic [DATA_ADDR_BITS+1:0]     echo_len;
  logic [DATA_ADDR_BITS:0]       resp_len;
  logic [MAX_DATA_SIZE-1:0]      ack_mask;
  logic                          ack_received;
  logic [MAX_DATA_SIZE-1:0][7:0] rx_data;
  logic [DATA_ADDR_BITS:0]       rx_count;
  logic                          error_ack;
  logic                          error_timeout;
  logic [7:0]                    fifo_data;
  logic                          fifo_rd_en;
  logic                          fifo_empty;

  modport master (
    output start, echo_len, resp_len, ack_mask, fifo_data, fifo_empty,
    input  ready, done, ack_received, rx_data, rx_count, error_ack, error_timeout, fifo_rd_en
  );

  modport slave (
    input  start, echo_len, resp_len, ack_mask, fifo_data, fifo_empty,
    output ready, done, ack_received, rx_data, rx_count, error_ack, error_timeout, fifo_rd_en
  );
endinterface

// File: rtl/updi_response_queue_handler_timeout.sv
// Clear/increment counter that flags expiry once it has counted TIMEOUT_CYCLES-1 steps.
// Saturates at the expiry value so a stalled caller never wraps it.
module updi_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TIMEOUT_BITS   = $clog2(TIMEOUT_CYCLES+1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic incr,
  output logic expired
);
  logic [TIMEOUT_BITS-1:0] count;

  assign expired = (count == TIMEOUT_BITS'(TIMEOUT_CYCLES-1));

  always_ff @(posedge clk) begin
    if (rst || clear) count <= '0;
    else if (incr && !expired) count <= count + 1'b1;
  end
endmodule

// File: rtl/updi_response_queue_handler.sv
// RX side of the UPDI link: drops the echo of transmitted bytes, captures the response
// bytes, validates ACK positions and reports completion/error per instruction.
//   state   | meaning
//   IDLE    | waiting for start, ready high
//   ISSUE   | waiting for a byte in the RX FIFO, popping it when present
//   CAPTURE | popped byte valid on fifo_data, discard (echo) or store (response)
module updi_response_queue_handler
  import updi_pkg::*;
#(
  parameter int MAX_DATA_SIZE  = 16,
  parameter int DATA_ADDR_BITS = $clog2(MAX_DATA_SIZE),
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TIMEOUT_BITS   = $clog2(TIMEOUT_CYCLES+1)
) (
  input logic clk,
  input logic rst,
  updi_response_queue_handler_if.slave bus
);
  localparam int CNT_BITS = DATA_ADDR_BITS + 2;
  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_ISSUE   = ISSUE;
  localparam logic [1:0] S_CAPTURE = CAPTURE;
  localparam logic       PH_ECHO   = ECHO;
  localparam logic       PH_RESP   = RESP;

  logic [1:0]               state;
  logic                     phase;
  logic [CNT_BITS-1:0]      counter;
  logic [CNT_BITS-1:0]      echo_len_q;
  logic [CNT_BITS-1:0]      resp_len_q;
  logic [CNT_BITS-1:0]      resp_len_clamped;
  logic [MAX_DATA_SIZE-1:0] ack_mask_q;
  logic                     tmr_clear;
  logic                     tmr_incr;
  logic                     tmr_expired;
  logic                     last_echo;
  logic                     last_resp;
  logic                     ack_pos;
  logic                     ack_ok;

  always_comb begin
    resp_len_clamped = CNT_BITS'(bus.resp_len);
    if (resp_len_clamped > CNT_BITS'(MAX_DATA_SIZE)) resp_len_clamped = CNT_BITS'(MAX_DATA_SIZE);
  end

  assign bus.fifo_rd_en = (state == S_ISSUE) && !bus.fifo_empty;
  assign tmr_clear      = ((state == S_IDLE) && bus.start) || bus.fifo_rd_en;
  assign tmr_incr       = (state == S_ISSUE) && bus.fifo_empty;
  assign last_echo      = (counter == echo_len_q - 1'b1);
  assign last_resp      = (counter == resp_len_q - 1'b1);
  assign ack_pos        = ack_mask_q[counter[DATA_ADDR_BITS-1:0]];
  assign ack_ok         = (bus.fifo_data == UPDI_ACK);

  updi_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMEOUT_BITS  (TIMEOUT_BITS)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmr_clear),
    .incr   (tmr_incr),
    .expired(tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      phase             <= PH_ECHO;
      counter           <= '0;
      echo_len_q        <= '0;
      resp_len_q        <= '0;
      ack_mask_q        <= '0;
      bus.ready         <= 1'b0;
      bus.done          <= 1'b0;
      bus.ack_received  <= 1'b0;
      bus.rx_data       <= '0;
      bus.rx_count      <= '0;
      bus.error_ack     <= 1'b0;
      bus.error_timeout <= 1'b0;
    end else begin
      bus.done         <= 1'b0;
      bus.ack_received <= 1'b0;
      case (state)
        S_IDLE: begin
          bus.ready <= 1'b1;
          if (bus.start) begin
            bus.ready         <= 1'b0;
            echo_len_q        <= bus.echo_len;
            resp_len_q        <= resp_len_clamped;
            ack_mask_q        <= bus.ack_mask;
            bus.rx_count      <= '0;
            bus.error_ack     <= 1'b0;
            bus.error_timeout <= 1'b0;
            counter           <= '0;
            if (bus.echo_len != '0) begin
              phase <= PH_ECHO;
              state <= S_ISSUE;
            end else if (resp_len_clamped != '0) begin
              phase <= PH_RESP;
              state <= S_ISSUE;
            end else begin
              bus.done <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (!bus.fifo_empty) begin
            state <= S_CAPTURE;
          end else if (tmr_expired) begin
            bus.error_timeout <= 1'b1;
            bus.done          <= 1'b1;
            bus.ready         <= 1'b1;
            state             <= S_IDLE;
          end
        end
        S_CAPTURE: begin
          if (phase == PH_ECHO) begin
            if (!last_echo) begin
              counter <= counter + 1'b1;
              state   <= S_ISSUE;
            end else if (resp_len_q == '0) begin
              bus.done  <= 1'b1;
              bus.ready <= 1'b1;
              state     <= S_IDLE;
            end else begin
              counter <= '0;
              phase   <= PH_RESP;
              state   <= S_ISSUE;
            end
          end else begin
            bus.rx_data[counter[DATA_ADDR_BITS-1:0]] <= bus.fifo_data;
            bus.rx_count <= bus.rx_count + 1'b1;
            // A wrong byte in an ACK slot aborts; the rest of the response stays in the FIFO.
            if (ack_pos && !ack_ok) begin
              bus.error_ack <= 1'b1;
              bus.done      <= 1'b1;
              bus.ready     <= 1'b1;
              state         <= S_IDLE;
            end else begin
              bus.ack_received <= ack_pos;
              if (last_resp) begin
                bus.done  <= 1'b1;
                bus.ready <= 1'b1;
                state     <= S_IDLE;
              end else begin
                counter <= counter + 1'b1;
                state   <= S_ISSUE;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_updi_response_queue_handler.sv
// Directed and randomized checks of the UPDI response queue handler against a
// transaction-level model of echo stripping, response capture and ACK checking.
module tb_updi_response_queue_handler;
  localparam int MAX  = 16;
  localparam int TMO  = 8;
  localparam int HALF = 5;

  logic clk;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  updi_response_queue_handler_if #(.MAX_DATA_SIZE(MAX)) bus ();

  updi_response_queue_handler #(
    .MAX_DATA_SIZE (MAX),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #HALF clk = ~clk;
  end

  // RX FIFO model: the test writes at wr_ptr, the DUT pops at rd_ptr
  logic [7:0] fifo_mem [0:4095];
  int  wr_ptr = 0;
  int  rd_ptr = 0;
  int  n_pops = 0;
  time last_pop_t = 0;

  assign bus.fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      bus.fifo_data <= fifo_mem[rd_ptr & 4095];
      rd_ptr        <= rd_ptr + 1;
      n_pops        <= n_pops + 1;
      last_pop_t    <= $time;
    end
  end

  logic [7:0]          stim [$];
  logic [MAX-1:0][7:0] model_data;
  int                  last_done_cyc;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_mem[wr_ptr & 4095] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  // Runs one instruction with the bytes in stim; gap>0 delivers one byte every gap cycles.
  task automatic run_txn(input string name, input int el, input int rl,
                         input logic [MAX-1:0] mask, input int gap, input int inj_at);
    int n, exp_pops, exp_cnt, exp_acks, pushed, dones, acks, pops0, timing_bad, done_cyc;
    logic exp_err_ack, exp_tmo;

    n = (rl > MAX) ? MAX : rl;
    exp_pops = 0; exp_cnt = 0; exp_acks = 0; exp_err_ack = 1'b0; exp_tmo = 1'b0;
    if (stim.size() < el) begin
      exp_tmo  = 1'b1;
      exp_pops = stim.size();
    end else begin
      exp_pops = el;
      for (int i = 0; i < n; i++) begin
        if (el + i >= stim.size()) begin
          exp_tmo = 1'b1;
          break;
        end
        model_data[i] = stim[el+i];
        exp_cnt++;
        exp_pops++;
        if (mask[i]) begin
          if (stim[el+i] == 8'h40) exp_acks++;
          else begin
            exp_err_ack = 1'b1;
            break;
          end
        end
      end
    end

    @(negedge clk);
    wr_ptr = rd_ptr;
    pushed = 0;
    if (gap == 0) begin
      while (pushed < stim.size()) begin
        push_byte(stim[pushed]);
        pushed++;
      end
    end else if (stim.size() > 0) begin
      push_byte(stim[0]);
      pushed = 1;
    end
    pops0 = n_pops;
    bus.echo_len = 6'(el);
    bus.resp_len = 5'(rl);
    bus.ack_mask = mask;
    bus.start    = 1'b1;

    dones = 0; acks = 0; timing_bad = 0; done_cyc = -1;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      if (bus.done) begin
        dones++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (bus.ack_received) begin
        acks++;
        if (($time - last_pop_t) != 3 * HALF) timing_bad++;
      end
      if (gap > 0 && pushed < stim.size() && (c % gap) == 0) begin
        push_byte(stim[pushed]);
        pushed++;
      end
      if (inj_at > 0 && c == inj_at) begin
        bus.echo_len = 6'd5;
        bus.resp_len = 5'd1;
        bus.start    = 1'b1;
      end
      if (inj_at > 0 && c == inj_at + 1) bus.start = 1'b0;
      if (done_cyc > 0 && c >= done_cyc + 3) break;
    end
    last_done_cyc = done_cyc;

    check({name, ".done_count"}, 128'(dones), 128'(1));
    check({name, ".pops"}, 128'(n_pops - pops0), 128'(exp_pops));
    check({name, ".rx_count"}, 128'(bus.rx_count), 128'(exp_cnt));
    check({name, ".rx_data"}, bus.rx_data, model_data);
    check({name, ".error_ack"}, 128'(bus.error_ack), 128'(exp_err_ack));
    check({name, ".error_timeout"}, 128'(bus.error_timeout), 128'(exp_tmo));
    check({name, ".acks"}, 128'(acks), 128'(exp_acks));
    check({name, ".ack_timing"}, 128'(timing_bad), 128'(0));
    check({name, ".ready"}, 128'(bus.ready), 128'(1));
  endtask

  initial begin
    int el, rl, n, full, nb;
    logic [MAX-1:0] mask;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.echo_len = '0;
    bus.resp_len = '0;
    bus.ack_mask = '0;
    model_data = '0;
    repeat (3) @(negedge clk);
    check("reset.ready", 128'(bus.ready), 128'(0));
    check("reset.done", 128'(bus.done), 128'(0));
    check("reset.rx_data", bus.rx_data, 128'(0));
    check("reset.rx_count", 128'(bus.rx_count), 128'(0));
    check("reset.errors", 128'({bus.error_ack, bus.error_timeout, bus.ack_received}), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    check("reset.ready_rise", 128'(bus.ready), 128'(1));

    stim = '{8'h55, 8'h80, 8'h30};
    run_txn("ldcs", 2, 1, 16'h0000, 0, 0);

    stim = '{8'h40, 8'h40};
    run_txn("st_ack", 0, 2, 16'h0003, 0, 0);

    stim = '{8'h00, 8'h12};
    run_txn("bad_ack", 0, 2, 16'h0001, 0, 0);
    check("bad_ack.left_in_fifo", 128'(wr_ptr - rd_ptr), 128'(1));

    stim = {};
    run_txn("timeout", 0, 1, 16'h0000, 0, 0);
    check("timeout.latency", 128'(last_done_cyc), 128'(TMO + 1));

    stim = '{8'h11, 8'h22, 8'h33};
    run_txn("slow", 0, 3, 16'h0000, 6, 0);

    stim = {};
    run_txn("zero_len", 0, 0, 16'h0000, 0, 0);

    stim = {};
    for (int i = 0; i < 18; i++) stim.push_back(8'(8'hA0 + i));
    run_txn("clamp", 0, 20, 16'h0000, 0, 0);

    stim = '{8'h5A, 8'h6B, 8'h7C};
    run_txn("start_ignored", 0, 3, 16'h0000, 6, 3);

    // Reset in the middle of a slow response
    @(negedge clk);
    wr_ptr = rd_ptr;
    push_byte(8'hC3);
    bus.echo_len = 6'd0;
    bus.resp_len = 5'd4;
    bus.ack_mask = '0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst.pre_count", 128'(bus.rx_count), 128'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_data = '0;
    check("midrst.outputs",
          128'({bus.ready, bus.done, bus.ack_received, bus.error_ack, bus.error_timeout, bus.fifo_rd_en}),
          128'(0));
    check("midrst.rx_count", 128'(bus.rx_count), 128'(0));
    check("midrst.rx_data", bus.rx_data, 128'(0));
    @(negedge clk);
    check("midrst.ready_done", 128'({bus.ready, bus.done}), 128'(2'b10));

    stim = '{8'h40, 8'h9D};
    run_txn("after_rst", 0, 2, 16'h0001, 0, 0);

    for (int t = 0; t < 30; t++) begin
      el   = $urandom_range(0, 3);
      rl   = $urandom_range(0, 20);
      mask = 16'($urandom);
      n    = (rl > MAX) ? MAX : rl;
      full = el + n;
      nb   = full;
      if (full > 0 && ($urandom % 5) == 0) nb = $urandom_range(0, full - 1);
      stim = {};
      for (int p = 0; p < nb; p++) begin
        if (p >= el && mask[p-el] && ($urandom % 8) != 0) stim.push_back(8'h40);
        else stim.push_back(8'($urandom));
      end
      run_txn("random", el, rl, mask, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
